mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage -- memory stage of a 16-bit in-order pipeline.
//
// Takes one instruction at a time from EX. ALU-class results are presented
// for writeback the cycle after acceptance. SW/CALL/LW/RET issue a single
// data-memory request and wait for mem_ack, bounded by TIMEOUT_CYCLES.
// A timeout sets the sticky err flag and drops the instruction.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   ex_valid/ex_ready EX handshake; ex_instr/ex_result/ex_rt latched on accept
//   flush             discard whatever is held; nothing is accepted that edge
//   mem_req/mem_we/mem_addr/mem_wdata  data-memory request (held until ack)
//   mem_rdata/mem_ack                  memory response
//   wb_valid/wb_instr/wb_data          one-cycle writeback strobe and payload
//   err               sticky memory-timeout flag
//
// Handshake: a transfer from EX happens on a rising edge where
// ex_valid=1, ex_ready=1 and flush=0. ex_ready depends only on state,
// never on ex_valid. The memory side has no ready: mem_req and its
// payload stay constant until an edge samples mem_ack=1.
//
// Opcode map (ex_instr[15:12]):
//   0 ADD  1 SUB  2 NAND 3 XOR  4 INC  5 SRA  6 SRL  7 SLL
//   8 LW   9 SW   A LHB  B LLB  C B    D CALL E RET  F undefined

module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [15:0] ex_instr,
    input  logic [15:0] ex_result,
    input  logic [15:0] ex_rt,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [15:0] wb_instr,
    output logic [15:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;

    // Last counter value before the timeout fires: the counter starts at 0
    // in the first WAIT cycle, so TIMEOUT_CYCLES-1 marks the final one.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [15:0] instr_q;
    logic [15:0] result_q;
    logic        load_q;

    logic [3:0]  op;
    logic        dec_alu;
    logic        dec_store;
    logic        dec_load;
    logic        accept;

    always_comb begin
        op        = ex_instr[15:12];
        dec_alu   = 1'b0;
        dec_store = 1'b0;
        dec_load  = 1'b0;
        // ALU class: 0-7 plus LHB/LLB (A, B).
        if (op <= 4'h7 || op == 4'hA || op == 4'hB) begin
            dec_alu = 1'b1;
        end
        if (op == OP_SW || op == OP_CALL) begin
            dec_store = 1'b1;
        end
        if (op == OP_LW || op == OP_RET) begin
            dec_load = 1'b1;
        end
    end

    // Gated by rst_n so ex_ready reads 0 while reset is held and 1 as
    // soon as it is released (state is IDLE at that point).
    assign ex_ready = rst_n & (state != S_WAIT);
    assign accept   = ex_valid & ex_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            instr_q   <= 16'd0;
            result_q  <= 16'd0;
            load_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            wb_valid  <= 1'b0;
            wb_instr  <= 16'd0;
            wb_data   <= 16'd0;
            err       <= 1'b0;
        end else if (flush) begin
            // Flush beats a simultaneous ack: the access may have happened
            // in memory, but nothing is retired.
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            wb_valid  <= 1'b0;
            wb_instr  <= 16'd0;
            wb_data   <= 16'd0;
        end else if (state == S_WAIT) begin
            if (mem_ack) begin
                state     <= S_DONE;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= 16'd0;
                mem_wdata <= 16'd0;
                wb_valid  <= 1'b1;
                wb_instr  <= instr_q;
                // Loads retire the read data; SW/CALL retire the EX result
                // (for CALL this is the updated stack pointer).
                wb_data   <= load_q ? mem_rdata : result_q;
            end else if (wait_cnt == TIMEOUT_LAST) begin
                state     <= S_IDLE;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= 16'd0;
                mem_wdata <= 16'd0;
                err       <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            // IDLE, HOLD, DONE: any presented result lasts one cycle, and a
            // new instruction may be taken in the same edge.
            state    <= S_IDLE;
            wb_valid <= 1'b0;
            wb_instr <= 16'd0;
            wb_data  <= 16'd0;
            if (accept) begin
                instr_q  <= ex_instr;
                result_q <= ex_result;
                load_q   <= dec_load;
                if (dec_alu) begin
                    state    <= S_HOLD;
                    wb_valid <= 1'b1;
                    wb_instr <= ex_instr;
                    wb_data  <= ex_result;
                end else if (dec_store || dec_load) begin
                    state     <= S_WAIT;
                    wait_cnt  <= 8'd0;
                    mem_req   <= 1'b1;
                    mem_we    <= dec_store;
                    mem_addr  <= ex_result;
                    mem_wdata <= dec_store ? ex_rt : 16'd0;
                end
                // B and undefined opcodes are consumed silently.
            end
        end
    end

endmodule
